// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_pkg
// Description : ALU opcode, main-control class and funct3 encodings, plus the
//               issue-stage entry layout shared by the design and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_pkg;

    localparam int C_XLEN  = 64;
    localparam int C_TAG_W = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1000;

    localparam logic [1:0] CLS_MEM_ADD    = 2'b00;
    localparam logic [1:0] CLS_BRANCH_SUB = 2'b01;
    localparam logic [1:0] CLS_RTYPE      = 2'b10;
    localparam logic [1:0] CLS_ITYPE      = 2'b11;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_NOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef struct packed {
        logic [C_XLEN-1:0]  a;
        logic [C_XLEN-1:0]  b;
        logic [3:0]         op;
        logic [C_TAG_W-1:0] tag;
        logic               illegal;
    } alu_entry_t;

endpackage : alu_issue_pkg
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Combinational class/funct3/funct7[5] decode to ALU opcode,
//               operand-B selection and illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_issue_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      i_alu_class,
    input  logic [2:0]      i_funct3,
    input  logic            i_funct7_b5,
    input  logic            i_alu_src,
    input  logic [XLEN-1:0] i_rs2_val,
    input  logic [XLEN-1:0] i_imm,
    output logic [3:0]      o_op,
    output logic [XLEN-1:0] o_b,
    output logic            o_illegal
);

    logic [XLEN-1:0] w_src;

    always_comb begin
        o_op      = ALU_ADD;
        o_illegal = 1'b0;
        w_src     = i_alu_src ? i_imm : i_rs2_val;
        case (i_alu_class)
            CLS_MEM_ADD:    o_op = ALU_ADD;
            CLS_BRANCH_SUB: o_op = ALU_SUB;
            CLS_RTYPE: begin
                w_src = i_rs2_val;
                case (i_funct3)
                    F3_ADD_SUB: o_op = i_funct7_b5 ? ALU_SUB : ALU_ADD;
                    F3_AND:     o_op = ALU_AND;
                    F3_OR:      o_op = ALU_OR;
                    F3_SLL:     o_op = ALU_SLL;
                    F3_NOR: begin
                        if (i_funct7_b5) o_op = ALU_NOR;
                        else             o_illegal = 1'b1;
                    end
                    default:    o_illegal = 1'b1;
                endcase
            end
            default: begin
                w_src = i_imm;
                case (i_funct3)
                    F3_ADD_SUB: o_op = ALU_ADD;
                    F3_AND:     o_op = ALU_AND;
                    F3_OR:      o_op = ALU_OR;
                    F3_SLL:     o_op = ALU_SLL;
                    default:    o_illegal = 1'b1;
                endcase
            end
        endcase
        // Shift amount is clamped to 6 bits so the ALU never multiplies by 2**B with B > 63.
        o_b = (o_op == ALU_SLL) ? {{(XLEN-6){1'b0}}, w_src[5:0]} : w_src;
    end

endmodule : alu_op_decode
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : ID/EX issue stage producing ALU operands/opcode behind a
//               valid/ready register; ALU_ISSUE_SKID_EN adds a skid entry.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_class,
    input  logic [2:0]       funct3,
    input  logic             funct7_b5,
    input  logic             alu_src,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [XLEN-1:0]  imm,
    input  logic [TAG_W-1:0] rd_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [3:0]       alu_op,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);

    typedef struct packed {
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [3:0]       op;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    localparam entry_t C_RESET_ENTRY = '{a: '0, b: '0, op: ALU_ADD, tag: '0, illegal: 1'b0};

    logic [3:0]      w_dec_op;
    logic [XLEN-1:0] w_dec_b;
    logic            w_dec_illegal;
    entry_t          w_in_entry;
    logic            w_accept;
    logic            w_xfer;

    entry_t          r_main;
    logic            r_main_valid;
    entry_t          w_main_nxt;
    logic            w_main_valid_nxt;

    alu_op_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .i_alu_class (alu_class),
        .i_funct3    (funct3),
        .i_funct7_b5 (funct7_b5),
        .i_alu_src   (alu_src),
        .i_rs2_val   (rs2_val),
        .i_imm       (imm),
        .o_op        (w_dec_op),
        .o_b         (w_dec_b),
        .o_illegal   (w_dec_illegal)
    );

    assign w_in_entry = '{a: rs1_val, b: w_dec_b, op: w_dec_op, tag: rd_tag, illegal: w_dec_illegal};
    assign w_accept   = in_valid && in_ready;
    assign w_xfer     = r_main_valid && out_ready;

`ifdef ALU_ISSUE_SKID_EN
    entry_t r_skid;
    logic   r_skid_valid;
    logic   r_in_ready;
    entry_t w_skid_nxt;
    logic   w_skid_valid_nxt;

    // Occupancy is encoded by the two valid bits: EMPTY, ONE (main only), FULL.
    always_comb begin
        w_main_nxt       = r_main;
        w_main_valid_nxt = r_main_valid;
        w_skid_nxt       = r_skid;
        w_skid_valid_nxt = r_skid_valid;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_main_valid) begin
            if (w_accept) begin
                w_main_nxt       = w_in_entry;
                w_main_valid_nxt = 1'b1;
            end
        end else if (!r_skid_valid) begin
            if (w_accept && w_xfer) begin
                w_main_nxt = w_in_entry;
            end else if (w_accept) begin
                w_skid_nxt       = w_in_entry;
                w_skid_valid_nxt = 1'b1;
            end else if (w_xfer) begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_xfer) begin
            w_main_nxt       = r_skid;
            w_skid_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid       <= C_RESET_ENTRY;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_skid       <= w_skid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
        end
    end

    assign in_ready = r_in_ready;
`else
    always_comb begin
        w_main_nxt       = r_main;
        w_main_valid_nxt = r_main_valid;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
        end else if (w_accept) begin
            w_main_nxt       = w_in_entry;
            w_main_valid_nxt = 1'b1;
        end else if (w_xfer) begin
            w_main_valid_nxt = 1'b0;
        end
    end

    assign in_ready = !r_main_valid || out_ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= C_RESET_ENTRY;
            r_main_valid <= 1'b0;
        end else begin
            r_main       <= w_main_nxt;
            r_main_valid <= w_main_valid_nxt;
        end
    end

    assign out_valid = r_main_valid;
    assign alu_a     = r_main.a;
    assign alu_b     = r_main.b;
    assign alu_op    = r_main.op;
    assign out_tag   = r_main.tag;
    assign illegal   = r_main.illegal;

endmodule : alu_issue_stage
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Self-checking bench for alu_issue_stage with a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

`ifdef ALU_ISSUE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_class;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        alu_src;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic [63:0] imm;
    logic [4:0]  rd_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  out_tag;
    logic        illegal;

    int          ncmp;
    int          nfail;
    logic        last_acc;
    alu_entry_t  q[$];

    alu_issue_stage #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_class(alu_class), .funct3(funct3), .funct7_b5(funct7_b5), .alu_src(alu_src),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .rd_tag(rd_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .out_tag(out_tag), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic alu_entry_t model(input logic [1:0] cls, input logic [2:0] f3, input logic b5,
                                         input logic src, input logic [63:0] a, input logic [63:0] r2,
                                         input logic [63:0] im, input logic [4:0] tag);
        alu_entry_t e;
        logic [63:0] bsrc;
        logic        sll;
        e.a = a; e.tag = tag; e.illegal = 1'b0; e.op = 4'b0010; sll = 1'b0;
        bsrc = src ? im : r2;
        if (cls == 2'b01) begin
            e.op = 4'b0110;
        end else if (cls == 2'b10) begin
            bsrc = r2;
            if (f3 == 3'd0)             e.op = b5 ? 4'b0110 : 4'b0010;
            else if (f3 == 3'd7)        e.op = 4'b0000;
            else if (f3 == 3'd6)        e.op = 4'b0001;
            else if (f3 == 3'd1)        begin e.op = 4'b1000; sll = 1'b1; end
            else if (f3 == 3'd4 && b5)  e.op = 4'b1100;
            else                        e.illegal = 1'b1;
        end else if (cls == 2'b11) begin
            bsrc = im;
            if (f3 == 3'd0)             e.op = 4'b0010;
            else if (f3 == 3'd7)        e.op = 4'b0000;
            else if (f3 == 3'd6)        e.op = 4'b0001;
            else if (f3 == 3'd1)        begin e.op = 4'b1000; sll = 1'b1; end
            else                        e.illegal = 1'b1;
        end
        e.b = sll ? (bsrc & 64'h3F) : bsrc;
        return e;
    endfunction

    task automatic set_instr(input logic [1:0] cls, input logic [2:0] f3, input logic b5, input logic src,
                             input logic [63:0] a, input logic [63:0] r2, input logic [63:0] im,
                             input logic [4:0] tag);
        in_valid = 1'b1; alu_class = cls; funct3 = f3; funct7_b5 = b5; alu_src = src;
        rs1_val = a; rs2_val = r2; imm = im; rd_tag = tag;
    endtask

    // One clock: score the transfer and accept seen at the edge, then step past it.
    task automatic tick();
        alu_entry_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 64'(out_tag), 64'hFFFF);
            end else begin
                e = q.pop_front();
                chk("sb_tag", 64'(out_tag), 64'(e.tag));
                chk("sb_a", alu_a, e.a);
                chk("sb_b", alu_b, e.b);
                chk("sb_op", 64'(alu_op), 64'(e.op));
                chk("sb_illegal", 64'(illegal), 64'(e.illegal));
            end
        end
        last_acc = in_valid && in_ready;
        if (flush) q.delete();
        else if (last_acc) q.push_back(model(alu_class, funct3, funct7_b5, alu_src, rs1_val, rs2_val, imm, rd_tag));
        @(posedge clk);
        #1;
    endtask

    task automatic send();
        int n;
        n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 50) begin
            tick();
            n++;
        end
        if (!last_acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 40) begin
            tick();
            n++;
        end
        if (q.size() != 0 || out_valid) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int k;
        ncmp = 0; nfail = 0; last_acc = 1'b0;
        rst_n = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; alu_class = 2'b00; funct3 = 3'd0; funct7_b5 = 1'b0; alu_src = 1'b0;
        rs1_val = '0; rs2_val = '0; imm = '0; rd_tag = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'h2);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_alu_b", alu_b, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // R-type SUB
        out_ready = 1'b1;
        set_instr(2'b10, 3'b000, 1'b1, 1'b0, 64'd10, 64'd3, 64'd99, 5'd1);
        send();
        chk("sub_valid", 64'(out_valid), 64'd1);
        chk("sub_op", 64'(alu_op), 64'h6);
        chk("sub_a", alu_a, 64'd10);
        chk("sub_b", alu_b, 64'd3);
        tick();

        // SLLI with shift amount clamped to 6 bits
        set_instr(2'b11, 3'b001, 1'b0, 1'b0, 64'd7, 64'd0, 64'h45, 5'd2);
        send();
        chk("slli_op", 64'(alu_op), 64'h8);
        chk("slli_b", alu_b, 64'd5);
        tick();

        // Unsupported R-type funct3
        set_instr(2'b10, 3'b010, 1'b0, 1'b0, 64'd5, 64'd6, 64'd0, 5'd3);
        send();
        chk("illegal_op", 64'(alu_op), 64'h2);
        chk("illegal_flag", 64'(illegal), 64'd1);
        tick();

        // Mixed decode patterns, back to back
        set_instr(2'b10, 3'b100, 1'b1, 1'b0, 64'h1234, 64'h00FF, 64'd0, 5'd4); send();
        set_instr(2'b10, 3'b100, 1'b0, 1'b0, 64'h1234, 64'h00FF, 64'd0, 5'd5); send();
        set_instr(2'b00, 3'b101, 1'b1, 1'b1, 64'd8, 64'd9, 64'hFFFF_FFFF_FFFF_FFF0, 5'd6); send();
        set_instr(2'b01, 3'b111, 1'b0, 1'b0, 64'd8, 64'd9, 64'd77, 5'd7); send();
        set_instr(2'b10, 3'b001, 1'b0, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd8); send();
        set_instr(2'b10, 3'b111, 1'b1, 1'b1, 64'hF0F0, 64'h0FF0, 64'h1, 5'd9); send();
        set_instr(2'b11, 3'b110, 1'b0, 1'b0, 64'hF000, 64'h1, 64'h000F, 5'd10); send();
        set_instr(2'b11, 3'b101, 1'b1, 1'b0, 64'd1, 64'd2, 64'd3, 5'd11); send();
        drain();

        // Backpressure: fill to capacity, then release
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            set_instr(2'b10, 3'b000, 1'b0, 1'b0, 64'(100 + k), 64'(k), 64'd0, 5'(11 + k));
            tick();
            if (last_acc) k++;
        end
        chk("bp_accepted", 64'(k), 64'(CAP));
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_tag", 64'(out_tag), 64'd11);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("bp_no_gap", 64'(out_valid), 64'd1);
            if (k < 4) set_instr(2'b10, 3'b000, 1'b0, 1'b0, 64'(100 + k), 64'(k), 64'd0, 5'(11 + k));
            else in_valid = 1'b0;
            tick();
            if (last_acc) k++;
        end
        chk("bp_all_sent", 64'(k), 64'd4);
        chk("bp_sb_empty", 64'(q.size()), 64'd0);
        drain();

        // Random traffic
        for (int c = 0; c < 80; c++) begin
            if (!in_valid || last_acc) begin
                if ($urandom_range(0, 3) != 0)
                    set_instr(2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
                else
                    in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain();

        // Flush while full with a same-cycle input
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 3; c++) begin
            set_instr(2'b00, 3'd0, 1'b0, 1'b0, 64'(200 + k), 64'd1, 64'd0, 5'(20 + k));
            tick();
            if (last_acc) k++;
        end
        chk("fl_full_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        set_instr(2'b00, 3'd0, 1'b0, 1'b0, 64'd300, 64'd1, 64'd0, 5'd30);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("fl_no_ghost", 64'(out_valid), 64'd0);
        end

        // Asynchronous reset while an output is stalled
        out_ready = 1'b0;
        set_instr(2'b10, 3'b110, 1'b0, 1'b0, 64'd55, 64'd66, 64'd0, 5'd25);
        send();
        chk("ar_pre_valid", 64'(out_valid), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        chk("ar_alu_op", 64'(alu_op), 64'h2);
        chk("ar_tag", 64'(out_tag), 64'd0);
        q.delete();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        set_instr(2'b01, 3'd0, 1'b0, 1'b0, 64'd100, 64'd40, 64'd0, 5'd26);
        send();
        chk("ar_first_tag", 64'(out_tag), 64'd26);
        chk("ar_first_op", 64'(alu_op), 64'h6);
        drain();

        chk("final_sb_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule : tb_alu_issue_stage
`default_nettype wire
